demux_buffer: RTL and testbench

- Inverse of the datapath 2:1 mux: takes one 32-bit word stream plus a select bit and routes each word to one of two destinations.
- Each destination has its own small FIFO, so a stalled consumer does not block traffic to the other.
- Used where one producer (e.g. ALU result or fetch word) feeds two independent consumers over valid/ready handshakes.

---
 rtl/demux_buffer_pkg.sv | 18 +
 rtl/demux_buffer_if.sv | 37 +++
 rtl/demux_buffer_sync_fifo.sv | 96 +++++++++
 rtl/demux_buffer.sv | 84 ++++++++
 tb/tb_demux_buffer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_buffer_pkg.sv
// demux_buffer_pkg
// Shared definitions for the demux_buffer block: default sizing, the
// destination select encoding and the valid/ready handshake-fire helper.
package demux_buffer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 2;

    // Destination encoding carried on the select line.
    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    // A transfer happens on a clock edge where both sides agree.
    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/demux_buffer_if.sv
// demux_buffer_if
// Bundles the producer-side and both consumer-side handshakes of the
// demux_buffer.
//   master : the environment (producer drives in/select/in_valid,
//            consumers drive out1_ready/out2_ready)
//   slave  : the demux_buffer itself
interface demux_buffer_if
    import demux_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    logic [WIDTH-1:0]         in;
    logic                     select;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out1;
    logic                     out1_valid;
    logic                     out1_ready;
    logic [WIDTH-1:0]         out2;
    logic                     out2_valid;
    logic                     out2_ready;
    logic [$clog2(DEPTH):0]   count1;
    logic [$clog2(DEPTH):0]   count2;

    modport master (
        output in, select, in_valid, out1_ready, out2_ready,
        input  in_ready, out1, out1_valid, out2, out2_valid, count1, count2
    );

    modport slave (
        input  in, select, in_valid, out1_ready, out2_ready,
        output in_ready, out1, out1_valid, out2, out2_valid, count1, count2
    );

endinterface

// File: rtl/demux_buffer_sync_fifo.sv
// demux_buffer_sync_fifo
// Single-clock FIFO with registered storage and a registered occupancy
// counter. The head entry is always presented on dout_o.
//   clk, reset_n : clock, asynchronous active-low reset (flushes contents)
//   push_i/din_i : write din_i at the tail (ignored when full)
//   pop_i        : advance the head (ignored when empty)
//   dout_o       : head entry
//   full_o/empty_o/count_o : occupancy status
module demux_buffer_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push_s, do_pop_s;

    // Status flags and qualified push/pop so the FIFO protects itself
    // against overflow and underflow.
    always_comb begin
        full_o    = (count_q == CNT_FULL);
        empty_o   = (count_q == CNT_ZERO);
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        count_o   = count_q;
        dout_o    = mem_q[rd_ptr_q];
    end

    // Next-state for pointers (wrap modulo DEPTH via natural overflow) and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads zero while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/demux_buffer.sv
// demux_buffer
// Routes one word stream to one of two destinations according to select,
// each destination buffered by its own FIFO so a stalled consumer never
// blocks the other.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : producer handshake (in/select/in_valid/in_ready) and
//                  two consumer handshakes (outN/outN_valid/outN_ready)
//                  plus per-FIFO occupancy (count1/count2)
module demux_buffer
    import demux_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    demux_buffer_if.slave bus
);

    logic full1_s, full2_s;
    logic empty1_s, empty2_s;
    logic sel_full_s;
    logic in_ready_s;
    logic accept_s;
    logic push1_s, push2_s;
    logic pop1_s, pop2_s;

    // Select decode: in_ready looks only at the stored occupancy of the
    // addressed FIFO, never at the consumer ready lines.
    always_comb begin
        sel_full_s = 1'b1;
        push1_s    = 1'b0;
        push2_s    = 1'b0;
        case (bus.select)
            SEL_OUT1: sel_full_s = full1_s;
            SEL_OUT2: sel_full_s = full2_s;
            default:  sel_full_s = 1'b1;
        endcase
        if (reset_n) begin
            in_ready_s = !sel_full_s;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = hs_fire(bus.in_valid, in_ready_s);
        if (accept_s) begin
            push1_s = (bus.select == SEL_OUT1);
            push2_s = (bus.select == SEL_OUT2);
        end else begin
            push1_s = 1'b0;
            push2_s = 1'b0;
        end
        pop1_s = hs_fire(!empty1_s, bus.out1_ready);
        pop2_s = hs_fire(!empty2_s, bus.out2_ready);
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out1_valid = !empty1_s;
    assign bus.out2_valid = !empty2_s;

    demux_buffer_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push1_s),
        .pop_i   (pop1_s),
        .din_i   (bus.in),
        .dout_o  (bus.out1),
        .full_o  (full1_s),
        .empty_o (empty1_s),
        .count_o (bus.count1)
    );

    demux_buffer_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push2_s),
        .pop_i   (pop2_s),
        .din_i   (bus.in),
        .dout_o  (bus.out2),
        .full_o  (full2_s),
        .empty_o (empty2_s),
        .count_o (bus.count2)
    );

endmodule

// File: tb/tb_demux_buffer.sv
// tb_demux_buffer
// Self-checking bench for demux_buffer: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_demux_buffer;
    import demux_buffer_pkg::*;

    localparam int W = 32;
    localparam int D = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per destination, plus the words consumers took.
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] recv1[$];
    logic [W-1:0] recv2[$];
    bit           last_acc;

    demux_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    demux_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model using the inputs
    // already applied, then advance the model by the rules of the block.
    task automatic cycle();
        bit           exp_rdy;
        bit           acc, p1, p2, s;
        logic [W-1:0] w;
        #1;
        exp_rdy = bus.select ? (q2.size() < D) : (q1.size() < D);
        chk("in_ready",   64'(bus.in_ready),   64'(exp_rdy));
        chk("out1_valid", 64'(bus.out1_valid), 64'(q1.size() != 0));
        chk("out2_valid", 64'(bus.out2_valid), 64'(q2.size() != 0));
        chk("count1",     64'(bus.count1),     64'(q1.size()));
        chk("count2",     64'(bus.count2),     64'(q2.size()));
        if (q1.size() != 0) chk("out1_data", 64'(bus.out1), 64'(q1[0]));
        if (q2.size() != 0) chk("out2_data", 64'(bus.out2), 64'(q2[0]));
        acc = bus.in_valid && exp_rdy;
        p1  = bus.out1_ready && (q1.size() != 0);
        p2  = bus.out2_ready && (q2.size() != 0);
        w   = bus.in;
        s   = bus.select;
        @(posedge clk);
        if (p1) recv1.push_back(q1.pop_front());
        if (p2) recv2.push_back(q2.pop_front());
        if (acc) begin
            if (s) q2.push_back(w);
            else   q1.push_back(w);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic model_flush();
        q1.delete();
        q2.delete();
        recv1.delete();
        recv2.delete();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int           w;
        int           maxc;
        logic [W-1:0] a;

        bus.in         = 32'h0;
        bus.select     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        last_acc       = 1'b0;

        // ---- Reset / idle ----
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready0", 64'(bus.in_ready),   64'd0);
        chk("rst_out1_vld",  64'(bus.out1_valid), 64'd0);
        chk("rst_out2_vld",  64'(bus.out2_valid), 64'd0);
        chk("rst_count1",    64'(bus.count1),     64'd0);
        chk("rst_count2",    64'(bus.count2),     64'd0);
        chk("rst_out1",      64'(bus.out1),       64'd0);
        chk("rst_out2",      64'(bus.out2),       64'd0);
        bus.select = 1'b1;
        #1;
        chk("rst_in_ready1", 64'(bus.in_ready), 64'd0);
        reset_n = 1'b1;
        model_flush();
        bus.select = 1'b0;
        #1;
        chk("idle_rdy_sel0", 64'(bus.in_ready), 64'd1);
        bus.select = 1'b1;
        #1;
        chk("idle_rdy_sel1", 64'(bus.in_ready), 64'd1);
        cycle();
        bus.select = 1'b0;
        cycle();

        // ---- Routing ----
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in         = 32'h0000_0011;
        bus.select     = 1'b0;
        cycle();
        chk("route_out1_vld", 64'(bus.out1_valid), 64'd1);
        chk("route_out1",     64'(bus.out1),       64'h11);
        chk("route_out2_idle", 64'(bus.out2_valid), 64'd0);
        bus.in     = 32'h0000_0022;
        bus.select = 1'b1;
        cycle();
        chk("route_out2_vld", 64'(bus.out2_valid), 64'd1);
        chk("route_out2",     64'(bus.out2),       64'h22);
        chk("route_out1_gone", 64'(bus.out1_valid), 64'd0);
        bus.in_valid = 1'b0;
        cycle();

        // ---- Backpressure / full ----
        recv1.delete();
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.select     = 1'b0;
        bus.in = 32'hA; cycle();
        bus.in = 32'hB; cycle();
        bus.in = 32'hC;
        #1;
        chk("bp_count1", 64'(bus.count1),   64'd2);
        chk("bp_rdy0",   64'(bus.in_ready), 64'd0);
        cycle();
        chk("bp_c_held", 64'(last_acc), 64'd0);
        bus.select = 1'b1;
        bus.in     = 32'hD;
        #1;
        chk("bp_rdy_sel1", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("bp_d_acc", 64'(last_acc), 64'd1);
        bus.select     = 1'b0;
        bus.in         = 32'hC;
        bus.out1_ready = 1'b1;
        for (int c = 0; c < 10 && bus.in_valid; c++) begin
            cycle();
            if (last_acc) bus.in_valid = 1'b0;
        end
        bus.out2_ready = 1'b1;
        repeat (3) cycle();
        chk("bp_recv_n", 64'(recv1.size()), 64'd3);
        if (recv1.size() == 3) begin
            chk("bp_recv0", 64'(recv1[0]), 64'hA);
            chk("bp_recv1", 64'(recv1[1]), 64'hB);
            chk("bp_recv2", 64'(recv1[2]), 64'hC);
        end

        // ---- Simultaneous push/pop ----
        bus.out1_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.select     = 1'b0;
        bus.in         = 32'h5;
        cycle();
        chk("pp_count_a", 64'(bus.count1), 64'd1);
        chk("pp_head_a",  64'(bus.out1),   64'h5);
        bus.in         = 32'h6;
        bus.out1_ready = 1'b1;
        cycle();
        chk("pp_count_b", 64'(bus.count1), 64'd1);
        chk("pp_head_b",  64'(bus.out1),   64'h6);
        bus.in_valid = 1'b0;
        cycle();

        // ---- Wrap-around with toggling consumer ----
        recv1.delete();
        w    = 1;
        maxc = 0;
        bus.select = 1'b0;
        for (int c = 0; c < 200 && (w <= 10 || q1.size() != 0); c++) begin
            bus.out1_ready = c[0];
            bus.in_valid   = (w <= 10);
            bus.in         = W'(w);
            cycle();
            if (last_acc) w++;
            if (int'(bus.count1) > maxc) maxc = int'(bus.count1);
        end
        bus.in_valid = 1'b0;
        chk("wrap_sent",  64'(w), 64'd11);
        chk("wrap_max",   64'(maxc <= D), 64'd1);
        chk("wrap_recvn", 64'(recv1.size()), 64'd10);
        for (int i = 0; i < recv1.size(); i++) begin
            chk("wrap_order", 64'(recv1[i]), 64'(i + 1));
        end

        // ---- Randomized traffic ----
        last_acc = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in       = $urandom;
                bus.select   = 1'($urandom_range(0, 1));
            end
            bus.out1_ready = 1'($urandom_range(0, 1));
            bus.out2_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        repeat (3) cycle();

        // ---- Reset in the middle of traffic ----
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.select = 1'b0; bus.in = 32'h31; cycle();
        bus.select = 1'b0; bus.in = 32'h32; cycle();
        bus.select = 1'b1; bus.in = 32'h41; cycle();
        bus.in_valid = 1'b0;
        chk("mr_count1_pre", 64'(bus.count1), 64'd2);
        chk("mr_count2_pre", 64'(bus.count2), 64'd1);
        reset_n = 1'b0;
        #2;
        chk("mr_out1_vld", 64'(bus.out1_valid), 64'd0);
        chk("mr_out2_vld", 64'(bus.out2_valid), 64'd0);
        chk("mr_count1",   64'(bus.count1),     64'd0);
        chk("mr_count2",   64'(bus.count2),     64'd0);
        chk("mr_in_ready", 64'(bus.in_ready),   64'd0);
        #2;
        reset_n = 1'b1;
        model_flush();
        bus.select     = 1'b0;
        bus.in         = 32'h77;
        bus.in_valid   = 1'b1;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        cycle();
        chk("mr_first_acc", 64'(last_acc), 64'd1);
        chk("mr_head",      64'(bus.out1), 64'h77);
        bus.in_valid = 1'b0;
        cycle();
        a = (recv1.size() != 0) ? recv1[0] : 32'h0;
        chk("mr_first_word", 64'(a), 64'h77);
        chk("mr_recv_n",     64'(recv1.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
